icache_refill: RTL and testbench

Direct-mapped, read-only instruction cache with a line-refill state machine, sitting between the core's PC/IF stage and a slower instruction memory. It presents the same fetch interface as the current synthesized ROM fetch (ena/addr in, registered valid/data out), but valid is a real signal: on a miss it drops low while a whole line is fetched word-by-word over a req/ack bus. The core stalls PC and IF while valid is low.

---
 rtl/icache_refill.sv | 180 ++++++++++++++++++
 tb/tb_icache_refill.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Direct-mapped read-only instruction cache with in-order line refill over a req/ack bus.
// Presents a registered valid/data fetch port; valid drops while a missed line is fetched.
module icache_refill #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;

  typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [LINES-1:0]         line_valid_q, line_valid_d;
  logic                     valid_q, valid_d;
  logic [31:0]              data_q, data_d;
  logic                     mem_req_q, mem_req_d;
  logic [31:0]              mem_addr_q, mem_addr_d;
  logic [OFFSET_BITS-1:0]   cnt_q, cnt_d;
  logic [TAG_BITS-1:0]      rtag_q, rtag_d;
  logic [INDEX_BITS-1:0]    ridx_q, ridx_d;
  logic [OFFSET_BITS-1:0]   roff_q, roff_d;
  logic                     flush_pend_q, flush_pend_d;

  logic [TAG_BITS-1:0]      tag_mem_q [LINES];
  logic [31:0]              word_mem_q [LINES*WORDS];

  logic [OFFSET_BITS-1:0]   off_s;
  logic [INDEX_BITS-1:0]    idx_s;
  logic [TAG_BITS-1:0]      tag_s;
  logic                     hit_s;
  logic                     last_s;
  logic [OFFSET_BITS-1:0]   cnt_inc_s;
  logic                     tag_we_s;
  logic                     fill_we_s;
  logic                     unused_s;

  assign off_s     = addr[OFFSET_BITS+1:2];
  assign idx_s     = addr[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
  assign tag_s     = addr[31:INDEX_BITS+OFFSET_BITS+2];
  assign unused_s  = ^addr[1:0];
  assign hit_s     = line_valid_q[idx_s] && (tag_mem_q[idx_s] == tag_s) && !flush;
  assign last_s    = (cnt_q == OFFSET_BITS'(WORDS - 1));
  assign cnt_inc_s = cnt_q + OFFSET_BITS'(1);

  assign valid    = valid_q;
  assign data     = data_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    valid_d      = valid_q;
    data_d       = data_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    cnt_d        = cnt_q;
    rtag_d       = rtag_q;
    ridx_d       = ridx_q;
    roff_d       = roff_q;
    flush_pend_d = flush_pend_q;
    tag_we_s     = 1'b0;
    fill_we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          line_valid_d = '0;
        end else begin
          line_valid_d = line_valid_q;
        end
        if (ena && hit_s) begin
          valid_d = 1'b1;
          data_d  = word_mem_q[{idx_s, off_s}];
        end else if (ena) begin
          // Evicted line is invalidated now so a partial fill can never hit.
          valid_d              = 1'b0;
          state_d              = REFILL;
          rtag_d               = tag_s;
          ridx_d               = idx_s;
          roff_d               = off_s;
          cnt_d                = '0;
          flush_pend_d         = 1'b0;
          mem_req_d            = 1'b1;
          mem_addr_d           = {tag_s, idx_s, {OFFSET_BITS{1'b0}}, 2'b00};
          line_valid_d[idx_s]  = 1'b0;
          tag_we_s             = 1'b1;
        end else begin
          valid_d = valid_q;
        end
      end
      REFILL: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (mem_ack && last_s) begin
          fill_we_s = 1'b1;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          valid_d   = 1'b1;
          if (roff_q == OFFSET_BITS'(WORDS - 1)) begin
            data_d = mem_data;
          end else begin
            data_d = word_mem_q[{ridx_q, roff_q}];
          end
          // A flush seen at any point during the refill wins over marking the line.
          if (flush_pend_q || flush) begin
            line_valid_d = '0;
            flush_pend_d = 1'b0;
          end else begin
            line_valid_d[ridx_q] = 1'b1;
          end
        end else if (mem_ack) begin
          fill_we_s  = 1'b1;
          cnt_d      = cnt_inc_s;
          mem_addr_d = {rtag_q, ridx_q, cnt_inc_s, 2'b00};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      line_valid_q <= '0;
      valid_q      <= 1'b0;
      data_q       <= 32'h0000_0000;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      cnt_q        <= '0;
      rtag_q       <= '0;
      ridx_q       <= '0;
      roff_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      cnt_q        <= cnt_d;
      rtag_q       <= rtag_d;
      ridx_q       <= ridx_d;
      roff_q       <= roff_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Tag and data storage carry no reset; the per-line valid bits guard them.
  always_ff @(posedge clk) begin
    if (tag_we_s) begin
      tag_mem_q[idx_s] <= tag_s;
    end
    if (fill_we_s) begin
      word_mem_q[{ridx_q, cnt_q}] <= mem_data;
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill with a transaction-level cache model and per-cycle compare.
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        flush = 1'b0;
  logic        valid;
  logic [31:0] data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = 32'h0;

  icache_refill dut (
    .clk(clk), .rst(rst), .ena(ena), .addr(addr), .flush(flush),
    .valid(valid), .data(data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: per-line valid/tag; memory contents are a fixed function of address.
  logic [15:0] mv = 16'h0;
  logic [23:0] mt [16];

  logic        chk_en = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data = 32'h0;
  logic        exp_req = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  int          req_cycles = 0;
  logic [31:0] acks_q [$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    memfn = 32'h0000_1000 + ((a - 32'h0040_0000) >> 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", {31'b0, valid}, {31'b0, exp_valid});
      chk("data", data, exp_data);
      chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      if (exp_req) chk("mem_addr", mem_addr, exp_addr);
      if (mem_req) req_cycles++;
      if (mem_req && mem_ack) acks_q.push_back(mem_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_pick(input int mode, input int cyc);
    if (mode == 1) ack_pick = 1'b1;
    else if (mode == 2) ack_pick = ((cyc % 3) == 2);
    else ack_pick = 1'($urandom_range(0, 1));
  endfunction

  task automatic fetch(input logic [31:0] a, input logic fl, input int mode,
                       input int flush_cyc, input int rst_after);
    int idx, k, cyc;
    logic [23:0] tg;
    logic hit, pend, took;
    idx = int'(a[7:4]);
    tg  = a[31:8];
    hit = !fl && mv[idx] && (mt[idx] == tg);
    ena = 1'b1; addr = a; flush = fl;
    if (fl) mv = 16'h0;
    tick();
    ena = 1'b0; flush = 1'b0; addr = $urandom;
    if (hit) begin
      exp_valid = 1'b1;
      exp_data  = memfn(a);
      return;
    end
    exp_valid = 1'b0; exp_req = 1'b1; exp_addr = {a[31:4], 4'h0};
    mv[idx] = 1'b0; mt[idx] = tg;
    k = 0; cyc = 0; pend = 1'b0;
    while (1) begin
      mem_ack  = ack_pick(mode, cyc);
      mem_data = mem_ack ? memfn(exp_addr) : $urandom;
      if (cyc == flush_cyc) begin
        flush = 1'b1;
        pend  = 1'b1;
      end
      tick();
      took = mem_ack; mem_ack = 1'b0; flush = 1'b0; cyc++;
      if (took) begin
        k++;
        if (k == 4) begin
          exp_req = 1'b0; exp_valid = 1'b1; exp_data = memfn(a);
          if (pend) mv = 16'h0; else mv[idx] = 1'b1;
          break;
        end
        exp_addr = exp_addr + 32'd4;
      end
      if (k == rst_after) begin
        rst = 1'b1;
        mv = 16'h0; exp_valid = 1'b0; exp_data = 32'h0; exp_req = 1'b0;
        #1;
        chk("rst_req_now", {31'b0, mem_req}, 32'h0);
        chk("rst_valid_now", {31'b0, valid}, 32'h0);
        tick();
        rst = 1'b0;
        break;
      end
      if (cyc > 300) begin
        chk("refill_timeout", cyc, 32'd300);
        break;
      end
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    mv = 16'h0;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    repeat (3) tick();
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_data", data, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Cold miss with ack tied high
    acks_q.delete();
    fetch(32'h0040_0000, 1'b0, 1, -1, -1);
    chk("fill0_nacks", acks_q.size(), 32'd4);
    if (acks_q.size() == 4) begin
      chk("fill0_a0", acks_q[0], 32'h0040_0000);
      chk("fill0_a1", acks_q[1], 32'h0040_0004);
      chk("fill0_a2", acks_q[2], 32'h0040_0008);
      chk("fill0_a3", acks_q[3], 32'h0040_000C);
    end
    chk("fill0_data", data, 32'h0000_1000);

    // Back-to-back hits
    req_cycles = 0;
    fetch(32'h0040_0004, 1'b0, 1, -1, -1);
    chk("b2b_1", data, 32'h0000_1001);
    fetch(32'h0040_0008, 1'b0, 1, -1, -1);
    chk("b2b_2", data, 32'h0000_1002);
    fetch(32'h0040_000C, 1'b0, 1, -1, -1);
    chk("b2b_3", data, 32'h0000_1003);
    chk("b2b_noreq", req_cycles, 32'd0);

    // Flush with ena in IDLE, slow memory, last word forwarded
    req_cycles = 0;
    fetch(32'h0040_000C, 1'b1, 2, -1, -1);
    chk("slow_reqcyc", req_cycles, 32'd12);
    chk("slow_data", data, 32'h0000_1003);

    // Conflict eviction
    fetch(32'h0040_0100, 1'b0, 1, -1, -1);
    chk("conf_data", data, 32'h0000_1040);
    req_cycles = 0;
    fetch(32'h0040_0000, 1'b0, 1, -1, -1);
    chk("conf_refetch_req", req_cycles, 32'd4);

    // Flush during refill
    fetch(32'h0040_0040, 1'b0, 0, 1, -1);
    chk("fmid_data", data, 32'h0000_1010);
    req_cycles = 0;
    fetch(32'h0040_0044, 1'b0, 1, -1, -1);
    chk("fmid_refetch_req", req_cycles, 32'd4);

    // Reset after second ack, then full refill
    fetch(32'h0040_0080, 1'b0, 1, -1, 2);
    acks_q.delete();
    fetch(32'h0040_0088, 1'b0, 0, -1, -1);
    chk("rst_refill_nacks", acks_q.size(), 32'd4);
    chk("rst_refill_data", data, 32'h0000_1022);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      ra = 32'h0040_0000 + ($urandom_range(0, 2) << 8) + ($urandom_range(0, 15) << 4)
           + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      case ($urandom_range(0, 15))
        0: do_flush();
        1: repeat ($urandom_range(1, 3)) tick();
        2: fetch(ra, 1'b1, $urandom_range(0, 2), -1, -1);
        3: fetch(ra, 1'b0, $urandom_range(0, 2), $urandom_range(0, 8), -1);
        default: fetch(ra, 1'b0, $urandom_range(0, 2), -1, -1);
      endcase
    end
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1);
  end

endmodule
